// File: rtl/rv_pkg.sv
// Shared constants for the mini-rv pipeline.
package rv_pkg;
   localparam int          XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
endpackage

// File: rtl/instr_mem.sv
// Word-addressed instruction ROM with an asynchronous read port.
module instr_mem
   import rv_pkg::*;
#(
   parameter int DEPTH = 1024
) (
   input  logic [XLEN-1:0] addr,
   output logic [XLEN-1:0] rdata
);
   localparam int AW = $clog2(DEPTH);

   logic [31:0] mem [DEPTH];

   // Byte offset and bits above the array size are dropped, so reads wrap.
   assign rdata = mem[addr[AW+1:2]];

   logic unused_addr;
   assign unused_addr = ^{addr[XLEN-1:AW+2], addr[1:0]};
endmodule

// File: rtl/fetch_stage.sv
// IF stage: program counter, instruction memory read and the IF/ID register.
module fetch_stage
   import rv_pkg::*;
#(
   parameter int          IMEM_DEPTH = 1024,
   parameter logic [31:0] RESET_PC   = rv_pkg::RESET_PC,
   parameter logic [31:0] NOP_INSTR  = rv_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            ex_if_branch_taken,
   input  logic [XLEN-1:0] ex_if_branch_target,
   output logic [XLEN-1:0] if_id_instr_data,
   output logic [XLEN-1:0] if_id_pc
);
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] imem_rdata;

   instr_mem #(
      .DEPTH(IMEM_DEPTH)
   ) i_mem (
      .addr (pc),
      .rdata(imem_rdata)
   );

   // Priority: reset, then redirect (flushes the wrong-path slot), then stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc               <= RESET_PC;
         if_id_pc         <= '0;
         if_id_instr_data <= NOP_INSTR;
      end else if (ex_if_branch_taken) begin
         pc               <= {ex_if_branch_target[XLEN-1:2], 2'b00};
         if_id_pc         <= '0;
         if_id_instr_data <= NOP_INSTR;
      end else if (!stall) begin
         pc               <= pc + 32'd4;
         if_id_pc         <= pc;
         if_id_instr_data <= imem_rdata;
      end
   end

   logic unused_target;
   assign unused_target = ^ex_if_branch_target[1:0];
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequential fetch, stall, redirect and wrap.
module tb_fetch_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        ex_if_branch_taken;
   logic [31:0] ex_if_branch_target;
   logic [31:0] if_id_instr_data;
   logic [31:0] if_id_pc;

   int n_checks = 0;
   int n_pass   = 0;
   logic [95:0] obs;
   logic [95:0] exp_q[$];
   logic [95:0] exp_v;

   localparam logic [31:0] NOP = 32'h0000_0013;

   fetch_stage dut (
      .clk                (clk),
      .rst                (rst),
      .stall              (stall),
      .ex_if_branch_taken (ex_if_branch_taken),
      .ex_if_branch_target(ex_if_branch_target),
      .if_id_instr_data   (if_id_instr_data),
      .if_id_pc           (if_id_pc)
   );

   // clock / reset
   always #5 clk = ~clk;

   // inputs change and outputs are sampled 1ns after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] word_of(input int idx);
      return 32'h1111_1111 * (idx + 1);
   endfunction

   task automatic load_mem();
      for (int i = 0; i < 1024; i++) dut.i_mem.mem[i] = 32'h0;
      for (int i = 0; i < 8; i++) dut.i_mem.mem[i] = word_of(i);
      dut.i_mem.mem[40]   = 32'hA0A0_0001;
      dut.i_mem.mem[64]   = 32'h1000_0064;
      dut.i_mem.mem[65]   = 32'h1000_0065;
      dut.i_mem.mem[1023] = 32'hFFFF_03FF;
   endtask

   task automatic test_reset();
      load_mem();
      rst = 1'b1; stall = 1'b0; ex_if_branch_taken = 1'b1; ex_if_branch_target = 32'h40;
      step();
      step();
      obs = {dut.pc, if_id_pc, if_id_instr_data};
      n_checks++;
      if (obs !== {32'h0, 32'h0, NOP}) $display("FAIL reset_over_branch: got %h required %h", obs, {32'h0, 32'h0, NOP});
      else n_pass++;
      ex_if_branch_taken = 1'b0; ex_if_branch_target = 32'h0;
      step();
      obs = {dut.pc, if_id_pc, if_id_instr_data};
      n_checks++;
      if (obs !== {32'h0, 32'h0, NOP}) $display("FAIL reset_state: got %h required %h", obs, {32'h0, 32'h0, NOP});
      else n_pass++;
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 5; i++)
         exp_q.push_back({32'(4 * (i + 1)), 32'(4 * i), word_of(i)});
      rst = 1'b0;
      while (exp_q.size() > 0) begin
         step();
         exp_v = exp_q.pop_front();
         obs = {dut.pc, if_id_pc, if_id_instr_data};
         n_checks++;
         if (obs !== exp_v) $display("FAIL seq_fetch: got %h required %h", obs, exp_v);
         else n_pass++;
      end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         obs = {dut.pc, if_id_pc, if_id_instr_data};
         n_checks++;
         if (obs !== {32'h14, 32'h10, word_of(4)}) $display("FAIL stall_hold: got %h required %h", obs, {32'h14, 32'h10, word_of(4)});
         else n_pass++;
      end
      stall = 1'b0;
      step();
      obs = {dut.pc, if_id_pc, if_id_instr_data};
      n_checks++;
      if (obs !== {32'h18, 32'h14, word_of(5)}) $display("FAIL stall_release: got %h required %h", obs, {32'h18, 32'h14, word_of(5)});
      else n_pass++;
   endtask

   task automatic test_branch();
      ex_if_branch_taken = 1'b1; ex_if_branch_target = 32'hA0;
      step();
      obs = {dut.pc, if_id_pc, if_id_instr_data};
      n_checks++;
      if (obs !== {32'hA0, 32'h0, NOP}) $display("FAIL branch_flush: got %h required %h", obs, {32'hA0, 32'h0, NOP});
      else n_pass++;
      ex_if_branch_taken = 1'b0;
      step();
      obs = {dut.pc, if_id_pc, if_id_instr_data};
      n_checks++;
      if (obs !== {32'hA4, 32'hA0, 32'hA0A0_0001}) $display("FAIL branch_target: got %h required %h", obs, {32'hA4, 32'hA0, 32'hA0A0_0001});
      else n_pass++;
   endtask

   task automatic test_branch_stall();
      stall = 1'b1; ex_if_branch_taken = 1'b1; ex_if_branch_target = 32'h0000_0103;
      step();
      obs = {dut.pc, if_id_pc, if_id_instr_data};
      n_checks++;
      if (obs !== {32'h100, 32'h0, NOP}) $display("FAIL branch_over_stall: got %h required %h", obs, {32'h100, 32'h0, NOP});
      else n_pass++;
      ex_if_branch_taken = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         obs = {dut.pc, if_id_pc, if_id_instr_data};
         n_checks++;
         if (obs !== {32'h100, 32'h0, NOP}) $display("FAIL stall_after_branch: got %h required %h", obs, {32'h100, 32'h0, NOP});
         else n_pass++;
      end
      stall = 1'b0;
      step();
      obs = {dut.pc, if_id_pc, if_id_instr_data};
      n_checks++;
      if (obs !== {32'h104, 32'h100, 32'h1000_0064}) $display("FAIL misaligned_target_fetch: got %h required %h", obs, {32'h104, 32'h100, 32'h1000_0064});
      else n_pass++;
   endtask

   task automatic test_not_taken();
      ex_if_branch_target = 32'h2000;
      step();
      obs = {dut.pc, if_id_pc, if_id_instr_data};
      n_checks++;
      if (obs !== {32'h108, 32'h104, 32'h1000_0065}) $display("FAIL not_taken: got %h required %h", obs, {32'h108, 32'h104, 32'h1000_0065});
      else n_pass++;
   endtask

   task automatic test_wrap();
      ex_if_branch_taken = 1'b1; ex_if_branch_target = 32'hFFC;
      step();
      ex_if_branch_taken = 1'b0;
      step();
      obs = {dut.pc, if_id_pc, if_id_instr_data};
      n_checks++;
      if (obs !== {32'h1000, 32'hFFC, 32'hFFFF_03FF}) $display("FAIL last_word: got %h required %h", obs, {32'h1000, 32'hFFC, 32'hFFFF_03FF});
      else n_pass++;
      step();
      obs = {dut.pc, if_id_pc, if_id_instr_data};
      n_checks++;
      if (obs !== {32'h1004, 32'h1000, word_of(0)}) $display("FAIL imem_wrap: got %h required %h", obs, {32'h1004, 32'h1000, word_of(0)});
      else n_pass++;
      ex_if_branch_taken = 1'b1; ex_if_branch_target = 32'hFFFF_FFFC;
      step();
      ex_if_branch_taken = 1'b0;
      step();
      obs = {dut.pc, if_id_pc, if_id_instr_data};
      n_checks++;
      if (obs !== {32'h0, 32'hFFFF_FFFC, 32'hFFFF_03FF}) $display("FAIL pc_wrap: got %h required %h", obs, {32'h0, 32'hFFFF_FFFC, 32'hFFFF_03FF});
      else n_pass++;
   endtask

   task automatic test_reset_midrun();
      step();
      rst = 1'b1; stall = 1'b1;
      step();
      obs = {dut.pc, if_id_pc, if_id_instr_data};
      n_checks++;
      if (obs !== {32'h0, 32'h0, NOP}) $display("FAIL reset_midrun: got %h required %h", obs, {32'h0, 32'h0, NOP});
      else n_pass++;
      rst = 1'b0; stall = 1'b0;
      dut.i_mem.mem[1] = 32'hCAFE_0001;
      step();
      step();
      obs = {dut.pc, if_id_pc, if_id_instr_data};
      n_checks++;
      if (obs !== {32'h8, 32'h4, 32'hCAFE_0001}) $display("FAIL mem_kept_and_live: got %h required %h", obs, {32'h8, 32'h4, 32'hCAFE_0001});
      else n_pass++;
   endtask

   initial begin
      #1;
      test_reset();
      test_sequential();
      test_stall();
      test_branch();
      test_branch_stall();
      test_not_taken();
      test_wrap();
      test_reset_midrun();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
